// File: rtl/encoder_time_set_ctrl.sv
// Time-set sequencer for the watch: debounced encoder button, hours/minutes/seconds
// shadow editing with wrap, commit pulse to the timekeeper, Avalon-MM status/control.
module encoder_time_set_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2,
    parameter int DEBOUNCE_W = 16,
    parameter int TIMEOUT_W  = 26
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enc_step,
    input  logic                  enc_dir,
    input  logic                  btn_raw,
    input  logic [4:0]            time_h_in,
    input  logic [5:0]            time_m_in,
    input  logic [5:0]            time_s_in,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic                  read,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic [4:0]            set_h,
    output logic [5:0]            set_m,
    output logic [5:0]            set_s,
    output logic                  load_time,
    output logic                  edit_active,
    output logic [1:0]            field_sel
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EDIT_H = 3'd1,
        ST_EDIT_M = 3'd2,
        ST_EDIT_S = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    localparam logic [DEBOUNCE_W-1:0] DB_MAX  = {DEBOUNCE_W{1'b1}};
    // Terminal compare one below all-ones so the edit lasts exactly 2^TIMEOUT_W-1 idle cycles.
    localparam logic [TIMEOUT_W-1:0]  TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    function automatic logic [5:0] wrap_step(input logic [5:0] val, input logic [5:0] max_val,
                                             input logic up);
        logic [5:0] res;
        if (up) begin
            if (val >= max_val) res = 6'd0;
            else                res = val + 6'd1;
        end else begin
            if (val == 6'd0)    res = max_val;
            else                res = val - 6'd1;
        end
        return res;
    endfunction

    logic                  btn_sync1_r, btn_sync2_r, btn_level_r, btn_press_r;
    logic [DEBOUNCE_W-1:0] db_cnt_r;
    logic [TIMEOUT_W-1:0]  to_cnt_r;
    state_t                state_r;
    logic [4:0]            set_h_r;
    logic [5:0]            set_m_r, set_s_r;
    logic                  load_time_r, edit_active_r, done_r, timeout_r;
    logic [1:0]            field_sel_r;
    logic [DATA_WIDTH-1:0] readdata_r;

    logic       wr_s, rd_s, in_edit_s, ctrl_wr_s, start_s, abort_s, timeout_s;
    logic       shadow_wr_s, status_wr_s, unused_wd_s;
    logic [5:0] step_h6_s, step_m_s, step_s_s;
    logic [4:0] nxt_h_s, sat_h_s;
    logic [5:0] nxt_m_s, nxt_s_s, sat_m_s, sat_s_s;

    assign unused_wd_s = ^writedata[DATA_WIDTH-1:17];

    // Decode bus accesses, event priorities and the next shadow values.
    always_comb begin
        wr_s        = chipselect & write;
        rd_s        = chipselect & read;
        in_edit_s   = (state_r == ST_EDIT_H) || (state_r == ST_EDIT_M) || (state_r == ST_EDIT_S);
        ctrl_wr_s   = wr_s && (address == ADDR_WIDTH'(1));
        start_s     = ctrl_wr_s && writedata[0] && (state_r == ST_IDLE);
        abort_s     = ctrl_wr_s && writedata[1] && in_edit_s;
        timeout_s   = in_edit_s && !enc_step && !btn_press_r && (to_cnt_r == TO_LAST);
        shadow_wr_s = wr_s && (address == ADDR_WIDTH'(2)) && in_edit_s;
        status_wr_s = wr_s && (address == ADDR_WIDTH'(0));

        step_h6_s = wrap_step({1'b0, set_h_r}, 6'd23, enc_dir);
        step_m_s  = wrap_step(set_m_r, 6'd59, enc_dir);
        step_s_s  = wrap_step(set_s_r, 6'd59, enc_dir);

        nxt_h_s = set_h_r;
        nxt_m_s = set_m_r;
        nxt_s_s = set_s_r;
        if (enc_step && (state_r == ST_EDIT_H)) begin
            nxt_h_s = step_h6_s[4:0];
        end else if (enc_step && (state_r == ST_EDIT_M)) begin
            nxt_m_s = step_m_s;
        end else if (enc_step && (state_r == ST_EDIT_S)) begin
            nxt_s_s = step_s_s;
        end else begin
            nxt_h_s = set_h_r;
        end

        if (writedata[16:12] > 5'd23) sat_h_s = 5'd23;
        else                          sat_h_s = writedata[16:12];
        if (writedata[11:6] > 6'd59)  sat_m_s = 6'd59;
        else                          sat_m_s = writedata[11:6];
        if (writedata[5:0] > 6'd59)   sat_s_s = 6'd59;
        else                          sat_s_s = writedata[5:0];
    end

    // Button synchronizer, debounce counter and rising-edge press pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_sync1_r <= 1'b0;
            btn_sync2_r <= 1'b0;
            btn_level_r <= 1'b0;
            btn_press_r <= 1'b0;
            db_cnt_r    <= '0;
        end else begin
            btn_sync1_r <= btn_raw;
            btn_sync2_r <= btn_sync1_r;
            btn_press_r <= 1'b0;
            if (btn_sync2_r != btn_level_r) begin
                if (db_cnt_r == DB_MAX) begin
                    btn_level_r <= btn_sync2_r;
                    btn_press_r <= btn_sync2_r;
                    db_cnt_r    <= '0;
                end else begin
                    db_cnt_r <= db_cnt_r + 1'b1;
                end
            end else begin
                db_cnt_r <= '0;
            end
        end
    end

    // Inactivity counter: runs only while editing, cleared by any user event or state change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_r <= '0;
        end else if (!in_edit_s || enc_step || btn_press_r || abort_s || timeout_s) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_r + 1'b1;
        end
    end

    // Edit FSM with shadow registers, sticky status bits and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            set_h_r       <= 5'd0;
            set_m_r       <= 6'd0;
            set_s_r       <= 6'd0;
            load_time_r   <= 1'b0;
            edit_active_r <= 1'b0;
            field_sel_r   <= 2'd0;
            done_r        <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            load_time_r <= 1'b0;
            done_r      <= (state_r == ST_COMMIT) || (done_r && !(status_wr_s && writedata[3]));
            timeout_r   <= (timeout_s && !abort_s) || (timeout_r && !(status_wr_s && writedata[4]));
            case (state_r)
                ST_IDLE: begin
                    if (btn_press_r || start_s) begin
                        set_h_r       <= time_h_in;
                        set_m_r       <= time_m_in;
                        set_s_r       <= time_s_in;
                        state_r       <= ST_EDIT_H;
                        edit_active_r <= 1'b1;
                        field_sel_r   <= 2'd1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
                    if (abort_s || timeout_s) begin
                        state_r       <= ST_IDLE;
                        edit_active_r <= 1'b0;
                        field_sel_r   <= 2'd0;
                    end else begin
                        if (shadow_wr_s) begin
                            set_h_r <= sat_h_s;
                            set_m_r <= sat_m_s;
                            set_s_r <= sat_s_s;
                        end else begin
                            set_h_r <= nxt_h_s;
                            set_m_r <= nxt_m_s;
                            set_s_r <= nxt_s_s;
                        end
                        if (btn_press_r) begin
                            case (state_r)
                                ST_EDIT_H: begin
                                    state_r     <= ST_EDIT_M;
                                    field_sel_r <= 2'd2;
                                end
                                ST_EDIT_M: begin
                                    state_r     <= ST_EDIT_S;
                                    field_sel_r <= 2'd3;
                                end
                                default: begin
                                    state_r       <= ST_COMMIT;
                                    load_time_r   <= 1'b1;
                                    edit_active_r <= 1'b0;
                                    field_sel_r   <= 2'd0;
                                end
                            endcase
                        end else begin
                            state_r <= state_r;
                        end
                    end
                end
                ST_COMMIT: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    edit_active_r <= 1'b0;
                    field_sel_r   <= 2'd0;
                end
            endcase
        end
    end

    // Registered Avalon read mux.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= '0;
        end else if (rd_s) begin
            case (address)
                ADDR_WIDTH'(0): readdata_r <= DATA_WIDTH'({timeout_r, done_r, field_sel_r, edit_active_r});
                ADDR_WIDTH'(2): readdata_r <= DATA_WIDTH'({set_h_r, set_m_r, set_s_r});
                default:        readdata_r <= '0;
            endcase
        end else begin
            readdata_r <= readdata_r;
        end
    end

    assign readdata    = readdata_r;
    assign set_h       = set_h_r;
    assign set_m       = set_m_r;
    assign set_s       = set_s_r;
    assign load_time   = load_time_r;
    assign edit_active = edit_active_r;
    assign field_sel   = field_sel_r;

endmodule

// File: tb/tb_encoder_time_set_ctrl.sv
// Directed bench for encoder_time_set_ctrl (8-cycle debounce, 63-cycle edit timeout).
module tb_encoder_time_set_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enc_step = 1'b0;
    logic        enc_dir = 1'b0;
    logic        btn_raw = 1'b0;
    logic [4:0]  time_h_in = 5'd0;
    logic [5:0]  time_m_in = 6'd0;
    logic [5:0]  time_s_in = 6'd0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [4:0]  set_h;
    logic [5:0]  set_m, set_s;
    logic        load_time, edit_active;
    logic [1:0]  field_sel;

    int total = 0;
    int bad = 0;
    int loads = 0;
    logic [31:0] rd;

    encoder_time_set_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .DEBOUNCE_W(3), .TIMEOUT_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .enc_step(enc_step), .enc_dir(enc_dir), .btn_raw(btn_raw),
        .time_h_in(time_h_in), .time_m_in(time_m_in), .time_s_in(time_s_in),
        .address(address), .chipselect(chipselect), .write(write), .read(read),
        .writedata(writedata), .readdata(readdata), .set_h(set_h), .set_m(set_m), .set_s(set_s),
        .load_time(load_time), .edit_active(edit_active), .field_sel(field_sel)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_time === 1'b1) loads++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step(input logic dir);
        enc_step = 1'b1;
        enc_dir  = dir;
        tick(1);
        enc_step = 1'b0;
    endtask

    // Sync (2) + 8 stable cycles -> press pulse; FSM reacts on the 11th edge, then release.
    task automatic press();
        btn_raw = 1'b1;
        tick(11);
        btn_raw = 1'b0;
        tick(12);
    endtask

    task automatic av_wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick(1);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic av_rd(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick(1);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    initial begin
        tick(3);
        chk("rst_hms", {15'd0, set_h, set_m, set_s}, 32'd0);
        chk("rst_flags", {29'd0, load_time, edit_active, field_sel}, 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Full walk from 23:59:58 to 00:57:59
        time_h_in = 5'd23; time_m_in = 6'd59; time_s_in = 6'd58;
        press();
        chk("a_field_h", {30'd0, field_sel}, 32'd1);
        chk("a_edit", {31'd0, edit_active}, 32'd1);
        chk("a_copy", {15'd0, set_h, set_m, set_s}, {15'd0, 5'd23, 6'd59, 6'd58});
        step(1'b1);
        chk("a_h_wrap", {27'd0, set_h}, 32'd0);
        press();
        chk("a_field_m", {30'd0, field_sel}, 32'd2);
        step(1'b0);
        step(1'b0);
        chk("a_m_57", {26'd0, set_m}, 32'd57);
        press();
        chk("a_field_s", {30'd0, field_sel}, 32'd3);
        step(1'b1);
        chk("a_s_59", {26'd0, set_s}, 32'd59);
        btn_raw = 1'b1;
        tick(10);
        chk("a_load_early", {31'd0, load_time}, 32'd0);
        tick(1);
        chk("a_load_pulse", {31'd0, load_time}, 32'd1);
        chk("a_commit_flags", {30'd0, edit_active, field_sel[0]}, 32'd0);
        tick(1);
        chk("a_load_end", {31'd0, load_time}, 32'd0);
        btn_raw = 1'b0;
        chk("a_final", {15'd0, set_h, set_m, set_s}, {15'd0, 5'd0, 6'd57, 6'd59});
        chk("a_loads", loads, 32'd1);
        tick(12);
        av_rd(2'd0, rd);
        chk("a_status_done", rd, 32'h8);
        av_wr(2'd0, 32'h8);
        av_rd(2'd0, rd);
        chk("a_done_w1c", rd, 32'h0);

        // Hours underflow, glitch rejection, same-cycle step + press in EDIT_S
        time_h_in = 5'd0; time_m_in = 6'd30; time_s_in = 6'd15;
        press();
        step(1'b0); step(1'b0); step(1'b0);
        chk("b_h_21", {27'd0, set_h}, 32'd21);
        btn_raw = 1'b1;
        tick(7);
        btn_raw = 1'b0;
        tick(15);
        chk("b_glitch", {30'd0, field_sel}, 32'd1);
        press();
        press();
        chk("b_field_s", {30'd0, field_sel}, 32'd3);
        av_wr(2'd2, {15'd0, 5'd21, 6'd30, 6'd59});
        chk("b_s_59", {26'd0, set_s}, 32'd59);
        btn_raw = 1'b1;
        tick(10);
        enc_step = 1'b1; enc_dir = 1'b1;
        tick(1);
        enc_step = 1'b0;
        chk("b_s_wrap", {26'd0, set_s}, 32'd0);
        chk("b_hm_kept", {15'd0, set_h, set_m, 6'd0}, {15'd0, 5'd21, 6'd30, 6'd0});
        chk("b_load", {31'd0, load_time}, 32'd1);
        chk("b_field_0", {30'd0, field_sel}, 32'd0);
        btn_raw = 1'b0;
        tick(13);
        chk("b_loads", loads, 32'd2);

        // Inactivity timeout
        time_h_in = 5'd12; time_m_in = 6'd34; time_s_in = 6'd56;
        av_wr(2'd1, 32'h1);
        chk("c_start", {30'd0, field_sel}, 32'd1);
        chk("c_copy_h", {27'd0, set_h}, 32'd12);
        tick(55);
        chk("c_still_edit", {31'd0, edit_active}, 32'd1);
        tick(15);
        chk("c_timed_out", {29'd0, edit_active, field_sel}, 32'd0);
        av_rd(2'd0, rd);
        chk("c_status", rd, 32'h18);
        av_wr(2'd0, 32'h10);
        av_rd(2'd0, rd);
        chk("c_to_w1c", rd, 32'h8);
        chk("c_loads", loads, 32'd2);

        // Avalon shadow saturation (70 exceeds the 6-bit field, so 62 stands in), start/abort
        time_h_in = 5'd5; time_m_in = 6'd5; time_s_in = 6'd5;
        av_wr(2'd1, 32'h1);
        av_wr(2'd2, {15'd0, 5'd30, 6'd5, 6'd62});
        av_rd(2'd2, rd);
        chk("d_shadow_sat", rd, 32'd94587);
        av_wr(2'd2, {15'd0, 5'd10, 6'd63, 6'd0});
        av_rd(2'd2, rd);
        chk("d_shadow_m_sat", rd, 32'd44736);
        step(1'b1);
        av_wr(2'd1, 32'h1);
        chk("d_start_ignored", {25'd0, set_h, field_sel}, {25'd0, 5'd11, 2'd1});
        av_rd(2'd1, rd);
        chk("d_ctrl_rd", rd, 32'd0);
        av_rd(2'd3, rd);
        chk("d_addr3_rd", rd, 32'd0);
        btn_raw = 1'b1;
        tick(10);
        chipselect = 1'b1; write = 1'b1; address = 2'd1; writedata = 32'h2;
        tick(1);
        chipselect = 1'b0; write = 1'b0;
        chk("d_abort", {29'd0, edit_active, field_sel}, 32'd0);
        chk("d_abort_noload", {31'd0, load_time}, 32'd0);
        btn_raw = 1'b0;
        tick(13);
        chk("d_loads", loads, 32'd2);
        av_wr(2'd2, 32'd0);
        chk("d_idle_shadow_wr", {27'd0, set_h}, 32'd11);

        // Reset in the middle of EDIT_M
        time_h_in = 5'd10; time_m_in = 6'd20; time_s_in = 6'd30;
        press();
        press();
        chk("e_edit_m", {30'd0, field_sel}, 32'd2);
        chk("e_shadow", {15'd0, set_h, set_m, set_s}, {15'd0, 5'd10, 6'd20, 6'd30});
        reset_n = 1'b0;
        tick(1);
        chk("e_rst_hms", {15'd0, set_h, set_m, set_s}, 32'd0);
        chk("e_rst_flags", {29'd0, load_time, edit_active, field_sel}, 32'd0);
        reset_n = 1'b1;
        tick(2);
        av_rd(2'd0, rd);
        chk("e_rst_status", rd, 32'd0);
        chk("e_loads", loads, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
